// File: rtl/prog_mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_seq_pkg
// Description : Shared types and sizes for the program-memory run sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

package prog_mem_seq_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int WORD_W = 8;
  localparam int OPC_W  = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prog_mem_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : CPU-rate prescaler counting 0..DIV-1 while enabled.
// Revision    : 1.0 - initial release
// ============================================================================

module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else if (enable) begin
      w_count_next = (r_count == c_last) ? '0 : r_count + CNT_W'(1);
    end
  end

  // tick looks one cycle ahead so the parent can register its clock-enable
  // and still have it high in exactly the cycle the count sits at DIV-1.
  assign tick = (clear || enable) && (w_count_next == c_last);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_sequencer
// Description : Loads the 16x8 program memory, then resets, runs or
//               single-steps the 4-bit CPU. Optional breakpoint support
//               is built when PROG_MEM_SEQ_BREAKPOINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================

module prog_mem_sequencer
  import prog_mem_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              run,
  input  logic              step,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_en,
  output logic              cpu_n_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [1:0]        state_o
`ifdef PROG_MEM_SEQ_BREAKPOINT_EN
  ,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit
`endif
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_cpu_en;
  logic              r_cpu_n_reset;
  logic              r_ld_ready;

  logic w_accept;
  logic w_go_run;
  logic w_run_live;
  logic w_ps_clear;
  logic w_tick;
  logic w_bp_stop;

  assign w_accept   = ld_valid && r_ld_ready;
  assign w_run_live = (r_state == ST_RUN) && run && !reload;
  assign w_ps_clear = (r_state == ST_HALT) && w_go_run && !reload;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (w_ps_clear),
    .enable  (w_run_live),
    .tick    (w_tick)
  );

`ifdef PROG_MEM_SEQ_BREAKPOINT_EN
  logic r_bp_hit;
  logic r_bp_exempt;
  logic r_run_d;

  // A latched breakpoint holds HALT until run is re-asserted (rising edge).
  assign w_go_run  = run && (!r_bp_hit || !r_run_d);
  assign w_bp_stop = w_tick && bp_valid && (cpu_addr == bp_addr) && !r_bp_exempt;
  assign bp_hit    = r_bp_hit;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_bp_hit    <= 1'b0;
      r_bp_exempt <= 1'b0;
      r_run_d     <= 1'b0;
    end else begin
      r_run_d <= run;
      if (reload) begin
        r_bp_hit <= 1'b0;
      end else if (w_run_live && w_bp_stop) begin
        r_bp_hit <= 1'b1;
      end else if (step || (run && !r_run_d)) begin
        r_bp_hit <= 1'b0;
      end
      if (w_ps_clear) begin
        r_bp_exempt <= 1'b1;
      end else if (w_run_live && w_tick) begin
        r_bp_exempt <= 1'b0;
      end
    end
  end
`else
  assign w_go_run  = run;
  assign w_bp_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= ST_LOAD;
      r_ptr         <= '0;
      r_cpu_en      <= 1'b0;
      r_cpu_n_reset <= 1'b0;
      r_ld_ready    <= 1'b1;
    end else begin
      r_cpu_en <= 1'b0;
      if (reload) begin
        r_state       <= ST_LOAD;
        r_ptr         <= '0;
        r_cpu_n_reset <= 1'b0;
        r_ld_ready    <= 1'b1;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_accept) begin
              r_ptr <= r_ptr + ADDR_W'(1);
              if (r_ptr == c_last_addr) begin
                // FLUSH gives the CPU one enabled edge with reset held low
                r_state    <= ST_FLUSH;
                r_cpu_en   <= 1'b1;
                r_ld_ready <= 1'b0;
              end
            end
          end
          ST_FLUSH: begin
            r_state       <= ST_HALT;
            r_cpu_n_reset <= 1'b1;
          end
          ST_HALT: begin
            if (w_go_run) begin
              r_state <= ST_RUN;
            end else if (step) begin
              r_cpu_en <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!run || w_bp_stop) begin
              r_state <= ST_HALT;
            end else begin
              r_cpu_en <= w_tick;
            end
          end
          default: r_state <= ST_LOAD;
        endcase
      end
    end
  end

  assign ld_ready    = r_ld_ready;
  assign cpu_en      = r_cpu_en;
  assign cpu_n_reset = r_cpu_n_reset;
  assign state_o     = r_state;
  assign mem_we      = w_accept;
  assign mem_wdata   = ld_data;
  assign mem_addr    = ((r_state == ST_LOAD) || (r_state == ST_FLUSH)) ? r_ptr : cpu_addr;

endmodule

`default_nettype wire
